// File: rtl/pc_redirect_pkg.sv
// Shared types and constants for the PC redirect controller.
package pc_redirect_pkg;

    localparam int ADDR_W_DEFAULT = 32;
    localparam int SHADOW_CNT_W   = 4;
    localparam int PERF_W         = 32;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REDIRECT = 2'd1,
        SHADOW   = 2'd2
    } state_e;

endpackage

// File: rtl/pc_redirect_controller_if.sv
// Bus between EX-stage branch logic / fetch side (master) and the redirect controller (slave).
interface pc_redirect_controller_if
    import pc_redirect_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEFAULT
);
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_target;
    logic              ex_stall;
    logic              fetch_busy;
    logic              pc_load;
    logic [ADDR_W-1:0] pc_target;
    logic              flush_if_id;
    logic              flush_id_ex;
    logic              redirect_busy;
    logic              redirect_misaligned;
    logic [PERF_W-1:0] perf_redirect_count;
    logic [PERF_W-1:0] perf_stall_count;

    modport master (
        output redirect_valid, redirect_target, ex_stall, fetch_busy,
        input  pc_load, pc_target, flush_if_id, flush_id_ex, redirect_busy,
               redirect_misaligned, perf_redirect_count, perf_stall_count
    );

    modport slave (
        input  redirect_valid, redirect_target, ex_stall, fetch_busy,
        output pc_load, pc_target, flush_if_id, flush_id_ex, redirect_busy,
               redirect_misaligned, perf_redirect_count, perf_stall_count
    );
endinterface

// File: rtl/redirect_perf_counter.sv
// Saturating event counter with enable; used for redirect statistics under REDIRECT_PERF_EN.
module redirect_perf_counter
    import pc_redirect_pkg::*;
#(
    parameter int WIDTH = PERF_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_en,
    output logic [WIDTH-1:0] o_count
);
    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_en && (r_count != '1)) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    assign o_count = r_count;
endmodule

// File: rtl/pc_redirect_controller.sv
// Sequences PC load and pipeline flushes for a taken branch/jump resolved in EX.
// Define REDIRECT_PERF_EN to build the redirect/stall performance counters.
module pc_redirect_controller
    import pc_redirect_pkg::*;
#(
    parameter int ADDR_W        = ADDR_W_DEFAULT,
    parameter int SHADOW_CYCLES = 1
) (
    input  logic               CLK,
    input  logic               RESET,
    pc_redirect_controller_if.slave bus
);
    localparam logic [SHADOW_CNT_W-1:0] SHADOW_LOAD =
        SHADOW_CNT_W'((SHADOW_CYCLES == 0) ? 0 : SHADOW_CYCLES - 1);

    state_e                  r_state;
    logic [ADDR_W-1:0]       r_target;
    logic [SHADOW_CNT_W-1:0] r_shadow_cnt;
    logic                    r_pc_load;
    logic                    r_flush_if_id;
    logic                    r_flush_id_ex;
    logic                    r_busy;
    logic                    r_misaligned;

    logic w_accept;
    logic w_unused_target_bit0;

    // A branch held in EX by a stall must fire only once, so stalls block acceptance.
    assign w_accept             = (r_state == IDLE) && bus.redirect_valid && !bus.ex_stall;
    assign w_unused_target_bit0 = bus.redirect_target[0];

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state       <= IDLE;
            r_target      <= '0;
            r_shadow_cnt  <= '0;
            r_pc_load     <= 1'b0;
            r_flush_if_id <= 1'b0;
            r_flush_id_ex <= 1'b0;
            r_busy        <= 1'b0;
            r_misaligned  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            r_misaligned <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_state       <= REDIRECT;
                        r_target      <= {bus.redirect_target[ADDR_W-1:2], 2'b00};
                        r_misaligned  <= bus.redirect_target[1];
                        r_pc_load     <= 1'b1;
                        r_flush_if_id <= 1'b1;
                        r_flush_id_ex <= 1'b1;
                        r_busy        <= 1'b1;
                    end
                end
                REDIRECT: begin
                    if (!bus.fetch_busy) begin
                        r_pc_load     <= 1'b0;
                        r_flush_id_ex <= 1'b0;
                        if (SHADOW_CYCLES == 0) begin
                            r_state       <= IDLE;
                            r_flush_if_id <= 1'b0;
                            r_busy        <= 1'b0;
                        end else begin
                            r_state      <= SHADOW;
                            r_shadow_cnt <= SHADOW_LOAD;
                        end
                    end
                end
                SHADOW: begin
                    if (r_shadow_cnt == '0) begin
                        r_state       <= IDLE;
                        r_flush_if_id <= 1'b0;
                        r_busy        <= 1'b0;
                    end else begin
                        r_shadow_cnt <= r_shadow_cnt - SHADOW_CNT_W'(1);
                    end
                end
                default: begin
                    r_state       <= IDLE;
                    r_pc_load     <= 1'b0;
                    r_flush_if_id <= 1'b0;
                    r_flush_id_ex <= 1'b0;
                    r_busy        <= 1'b0;
                end
            endcase
        end
    end

    assign bus.pc_load             = r_pc_load;
    assign bus.pc_target           = r_target;
    assign bus.flush_if_id         = r_flush_if_id;
    assign bus.flush_id_ex         = r_flush_id_ex;
    assign bus.redirect_busy       = r_busy;
    assign bus.redirect_misaligned = r_misaligned;

`ifdef REDIRECT_PERF_EN
    logic w_stall_en;
    assign w_stall_en = (r_state == REDIRECT) && bus.fetch_busy;

    redirect_perf_counter #(.WIDTH(PERF_W)) u_redirect_cnt (
        .clk     (CLK),
        .rst     (RESET),
        .i_en    (w_accept),
        .o_count (bus.perf_redirect_count)
    );

    redirect_perf_counter #(.WIDTH(PERF_W)) u_stall_cnt (
        .clk     (CLK),
        .rst     (RESET),
        .i_en    (w_stall_en),
        .o_count (bus.perf_stall_count)
    );
`else
    assign bus.perf_redirect_count = '0;
    assign bus.perf_stall_count    = '0;
`endif
endmodule

// File: tb/tb_pc_redirect_controller.sv
// Self-checking bench for pc_redirect_controller: directed scenarios plus randomized traffic
// compared every cycle against a cycle-count model of the redirect sequence.
module tb_pc_redirect_controller;
    localparam int ADDR_W = 32;
    localparam int SHADOW = 1;

    logic CLK = 1'b0;
    logic RESET;
    always #5 CLK = ~CLK;

    pc_redirect_controller_if #(.ADDR_W(ADDR_W)) bus ();

    pc_redirect_controller #(.ADDR_W(ADDR_W), .SHADOW_CYCLES(SHADOW)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Model: a pending PC load, a count of remaining shadow cycles, and the captured target.
    bit          m_load;
    int          m_shadow_left;
    logic [31:0] m_tgt;
    bit          m_mis;
    logic [63:0] m_perf_redir;
    logic [63:0] m_perf_stall;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] sat32(input logic [63:0] v);
        return (v > 64'h0000_0000_FFFF_FFFF) ? 32'hFFFF_FFFF : v[31:0];
    endfunction

    task automatic model_reset();
        m_load        = 1'b0;
        m_shadow_left = 0;
        m_tgt         = '0;
        m_mis         = 1'b0;
        m_perf_redir  = '0;
        m_perf_stall  = '0;
    endtask

    task automatic model_edge(input bit v, input logic [31:0] t, input bit s, input bit fb);
        m_mis = 1'b0;
        if (m_load) begin
            if (fb) begin
                m_perf_stall++;
            end else begin
                m_load        = 1'b0;
                m_shadow_left = SHADOW;
            end
        end else if (m_shadow_left > 0) begin
            m_shadow_left--;
        end else if (v && !s) begin
            m_load = 1'b1;
            m_tgt  = t & 32'hFFFF_FFFC;
            m_mis  = t[1];
            m_perf_redir++;
        end
    endtask

    task automatic compare_outputs();
        check("pc_load",       bus.pc_load,             m_load);
        check("flush_id_ex",   bus.flush_id_ex,         m_load);
        check("flush_if_id",   bus.flush_if_id,         m_load || (m_shadow_left > 0));
        check("redirect_busy", bus.redirect_busy,       m_load || (m_shadow_left > 0));
        check("pc_target",     bus.pc_target,           m_tgt);
        check("misaligned",    bus.redirect_misaligned, m_mis);
`ifdef REDIRECT_PERF_EN
        check("perf_redirect", bus.perf_redirect_count, sat32(m_perf_redir));
        check("perf_stall",    bus.perf_stall_count,    sat32(m_perf_stall));
`else
        check("perf_redirect", bus.perf_redirect_count, 32'h0);
        check("perf_stall",    bus.perf_stall_count,    32'h0);
`endif
    endtask

    // Drive at the falling edge, let one rising edge pass, compare at the next falling edge.
    task automatic step(input bit v, input logic [31:0] t, input bit s, input bit fb);
        bus.redirect_valid  = v;
        bus.redirect_target = t;
        bus.ex_stall        = s;
        bus.fetch_busy      = fb;
        @(posedge CLK);
        model_edge(v, t, s, fb);
        @(negedge CLK);
        compare_outputs();
    endtask

    task automatic do_reset();
        bus.redirect_valid  = 1'b0;
        bus.redirect_target = '0;
        bus.ex_stall        = 1'b0;
        bus.fetch_busy      = 1'b0;
        RESET = 1'b1;
        #1;
        model_reset();
        check("rst_pc_load", bus.pc_load,       32'h0);
        check("rst_busy",    bus.redirect_busy, 32'h0);
        check("rst_target",  bus.pc_target,     32'h0);
        compare_outputs();
        @(negedge CLK);
        RESET = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int loads;
        bus.redirect_valid  = 1'b0;
        bus.redirect_target = '0;
        bus.ex_stall        = 1'b0;
        bus.fetch_busy      = 1'b0;
        RESET = 1'b1;
        @(negedge CLK);
        do_reset();
        step(0, 32'h0, 0, 0);
        check("idle_flush_if_id", bus.flush_if_id, 32'h0);

        // Simple taken branch.
        step(1, 32'h0000_0104, 0, 0);
        check("br_pc_load",   bus.pc_load,     32'h1);
        check("br_pc_target", bus.pc_target,   32'h104);
        check("br_flush_ie",  bus.flush_id_ex, 32'h1);
        step(0, 32'h0, 0, 0);
        check("br_shadow_fif", bus.flush_if_id, 32'h1);
        check("br_shadow_pcl", bus.pc_load,     32'h0);
        step(0, 32'h0, 0, 0);
        check("br_idle_busy",  bus.redirect_busy, 32'h0);

        // Fetch busy hold.
        do_reset();
        step(1, 32'h0000_2000, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(0, 32'h0, 0, 1);
            check("hold_pc_load", bus.pc_load,   32'h1);
            check("hold_target",  bus.pc_target, 32'h2000);
        end
        step(0, 32'h0, 0, 0);
        check("hold_release", bus.pc_load, 32'h0);
`ifdef REDIRECT_PERF_EN
        check("hold_perf_stall", bus.perf_stall_count,    32'd3);
        check("hold_perf_redir", bus.perf_redirect_count, 32'd1);
`endif
        step(0, 32'h0, 0, 0);

        // ex_stall gating: branch held in EX fires once.
        loads = 0;
        for (int i = 0; i < 3; i++) begin
            step(1, 32'h0000_0300, 1, 0);
            check("stall_busy", bus.redirect_busy, 32'h0);
        end
        step(1, 32'h0000_0300, 0, 0);
        loads += int'(bus.pc_load);
        step(1, 32'h0000_0300, 0, 0);
        loads += int'(bus.pc_load);
        for (int i = 0; i < 2; i++) begin
            step(0, 32'h0, 0, 0);
            loads += int'(bus.pc_load);
        end
        check("stall_one_load", 32'(loads), 32'd1);

        // Misaligned JALR target.
        step(1, 32'h0000_0036, 0, 0);
        check("mis_pulse",  bus.redirect_misaligned, 32'h1);
        check("mis_target", bus.pc_target,           32'h34);
        step(0, 32'h0, 0, 0);
        check("mis_clear", bus.redirect_misaligned, 32'h0);
        step(0, 32'h0, 0, 0);
        step(0, 32'h0, 0, 0);

        // Reset asserted mid-REDIRECT.
        step(1, 32'h0000_0500, 0, 0);
        step(0, 32'h0, 0, 1);
        check("mid_in_redirect", bus.pc_load, 32'h1);
        do_reset();
        for (int i = 0; i < 3; i++) begin
            step(0, 32'h0, 0, 0);
            check("post_rst_no_load", bus.pc_load, 32'h0);
        end

        // Randomized traffic, including back-to-back redirects and occasional resets.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                do_reset();
            end else begin
                step($urandom_range(0, 2) == 0, $urandom,
                     $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
